// File: rtl/pool_pkg.sv
// Shared types and constants for the pool dictionary engines (FIND walker, ADD writer).
// DICT_ADD_ALIGN_EN adds the PAD state so every pfa lands on an even address.
package pool_pkg;

    localparam int          HDR_SZ  = 3;
    localparam logic [15:0] LFA_NIL = 16'hffff;

    typedef enum logic [1:0] {
        NOP  = 2'd0,
        ADD  = 2'd1,
        LOAD = 2'd2
    } dict_op;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LNK0 = 3'd1,
        S_LNK1 = 3'd2,
        S_HLEN = 3'd3,
        S_RD   = 3'd4,
        S_WR   = 3'd5,
`ifdef DICT_ADD_ALIGN_EN
        S_PAD  = 3'd6,
`endif
        S_DONE = 3'd7
    } dict_add_st;

    typedef enum logic [1:0] {
        POOL_NOP  = 2'd0,
        POOL_FIND = 2'd1,
        POOL_DICT = 2'd2
    } pool_ops;

    typedef enum logic [1:0] {
        STS_OK   = 2'd0,
        STS_MISS = 2'd1,
        STS_BUSY = 2'd2,
        STS_ERR  = 2'd3
    } pool_sts;

endpackage

// File: rtl/dict_add_if.sv
// Command and memory-port bundle between the pool top (master) and dict_add (slave).
interface dict_add_if #(
    parameter int ASZ = 17,
    parameter int DSZ = 8
);
    import pool_pkg::*;

    dict_op           op;
    logic [ASZ-1:0]   ai;
    logic [DSZ-1:0]   len;
    logic             mem_we;
    logic [ASZ-1:0]   mem_a;
    logic [DSZ-1:0]   mem_vo;
    logic [DSZ-1:0]   mem_vi;
    logic             bsy;
    logic             err;
    logic [ASZ-1:0]   here;
    logic [15:0]      ctx;

    modport master (
        output op, ai, len, mem_vi,
        input  mem_we, mem_a, mem_vo, bsy, err, here, ctx
    );

    modport slave (
        input  op, ai, len, mem_vi,
        output mem_we, mem_a, mem_vo, bsy, err, here, ctx
    );

endinterface

// File: rtl/dict_add.sv
// Dictionary writer: builds [lfa_lo][lfa_hi][len][name][pfa] at here, then links it into ctx.
// Define DICT_ADD_ALIGN_EN to pad odd pfa addresses with one 'h00 byte.
module dict_add
    import pool_pkg::*;
#(
    parameter int             DSZ   = 8,
    parameter int             ASZ   = 17,
    parameter int             NMAX  = 31,
    parameter logic [ASZ-1:0] TOP   = 'h1ffff,
    parameter logic [ASZ-1:0] HERE0 = 'h0100,
    parameter logic [15:0]    CTX0  = 16'hffff
) (
    input  logic       clk,
    input  logic       rst,
    dict_add_if.slave  bus
);

    dict_add_st       r_st;
    logic             r_bsy;
    logic             r_err;
    logic             r_we;
    logic [ASZ-1:0]   r_a;
    logic [DSZ-1:0]   r_vo;
    logic [ASZ-1:0]   r_here;
    logic [15:0]      r_ctx;
    logic [ASZ-1:0]   r_tib;
    logic [DSZ-1:0]   r_n;
    logic [15:0]      r_base;
    logic [ASZ-1:0]   r_wp;

    logic [ASZ:0]     w_pfa;
    logic [ASZ:0]     w_end;
    logic             w_ok;

    // End of the new entry, one bit wider than the address so overflow cannot wrap.
    always_comb begin
        w_pfa = {1'b0, r_here} + (ASZ+1)'(HDR_SZ) + (ASZ+1)'(bus.len);
        w_end = w_pfa;
`ifdef DICT_ADD_ALIGN_EN
        w_end = w_pfa + (ASZ+1)'(w_pfa[0]);
`endif
        w_ok  = (bus.len != '0) &&
                (bus.len <= DSZ'(NMAX)) &&
                (r_here[ASZ-1:16] == '0) &&
                (w_end <= {1'b0, TOP});
    end

    assign bus.mem_we = r_we;
    assign bus.mem_a  = r_a;
    // Name bytes stream straight from the read port into the write cycle that follows.
    assign bus.mem_vo = (r_st == S_WR) ? bus.mem_vi : r_vo;
    assign bus.bsy    = r_bsy;
    assign bus.err    = r_err;
    assign bus.here   = r_here;
    assign bus.ctx    = r_ctx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st   <= S_IDLE;
            r_bsy  <= 1'b0;
            r_err  <= 1'b0;
            r_we   <= 1'b0;
            r_a    <= '0;
            r_vo   <= '0;
            r_here <= HERE0;
            r_ctx  <= CTX0;
            r_tib  <= '0;
            r_n    <= '0;
            r_base <= '0;
            r_wp   <= '0;
        end else begin
            case (r_st)
                S_IDLE: begin
                    if (bus.op == LOAD) begin
                        r_here <= bus.ai;
                        r_err  <= 1'b0;
                    end else if (bus.op == ADD) begin
                        if (w_ok) begin
                            r_err  <= 1'b0;
                            r_bsy  <= 1'b1;
                            r_tib  <= bus.ai;
                            r_n    <= bus.len;
                            r_base <= r_here[15:0];
                            r_we   <= 1'b1;
                            r_a    <= r_here;
                            r_vo   <= r_ctx[7:0];
                            r_wp   <= r_here + 1'b1;
                            r_st   <= S_LNK0;
                        end else begin
                            r_err  <= 1'b1;
                        end
                    end
                end
                S_LNK0: begin
                    r_a  <= r_wp;
                    r_vo <= r_ctx[15:8];
                    r_wp <= r_wp + 1'b1;
                    r_st <= S_LNK1;
                end
                S_LNK1: begin
                    r_a  <= r_wp;
                    r_vo <= r_n;
                    r_wp <= r_wp + 1'b1;
                    r_st <= S_HLEN;
                end
                S_HLEN: begin
                    r_we  <= 1'b0;
                    r_a   <= r_tib;
                    r_tib <= r_tib + 1'b1;
                    r_st  <= S_RD;
                end
                S_RD: begin
                    r_we <= 1'b1;
                    r_a  <= r_wp;
                    r_wp <= r_wp + 1'b1;
                    r_st <= S_WR;
                end
                S_WR: begin
                    r_n <= r_n - 1'b1;
                    if (r_n == DSZ'(1)) begin
                        r_we <= 1'b0;
                        r_st <= S_DONE;
`ifdef DICT_ADD_ALIGN_EN
                        if (r_wp[0]) begin
                            r_we <= 1'b1;
                            r_a  <= r_wp;
                            r_vo <= '0;
                            r_wp <= r_wp + 1'b1;
                            r_st <= S_PAD;
                        end
`endif
                    end else begin
                        r_we  <= 1'b0;
                        r_a   <= r_tib;
                        r_tib <= r_tib + 1'b1;
                        r_st  <= S_RD;
                    end
                end
`ifdef DICT_ADD_ALIGN_EN
                S_PAD: begin
                    r_we <= 1'b0;
                    r_st <= S_DONE;
                end
`endif
                S_DONE: begin
                    r_here <= r_wp;
                    r_ctx  <= r_base;
                    r_bsy  <= 1'b0;
                    r_a    <= '0;
                    r_vo   <= '0;
                    r_st   <= S_IDLE;
                end
                default: begin
                    r_we  <= 1'b0;
                    r_bsy <= 1'b0;
                    r_st  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dict_add.sv
// Scoreboarded bench for dict_add with a behavioural 1-cycle-latency byte memory.
// Honours DICT_ADD_ALIGN_EN in its reference model.
module tb_dict_add;
    import pool_pkg::*;

    logic clk;
    logic rst;

    dict_add_if #(.ASZ(17), .DSZ(8)) bus ();

    dict_add dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [0:131071];
    logic [7:0]  tib_rom [0:255];
    logic [24:0] sb [$];

    int n_chk = 0;
    int n_err = 0;

    logic [16:0] m_here;
    logic [15:0] m_ctx;

    // Memory model: addresses below 'h100 hold the TIB text.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_a] <= bus.mem_vo;
        bus.mem_vi <= (bus.mem_a < 17'h100) ? tib_rom[bus.mem_a[7:0]] : mem[bus.mem_a];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (sb.size() == 0) begin
                check("unexp_wr", 32'(bus.mem_we), 32'd0);
            end else begin
                check("wr", {7'd0, bus.mem_a, bus.mem_vo}, {7'd0, sb.pop_front()});
            end
        end
    end

    task automatic load_str(input int base, input string s);
        for (int i = 0; i < s.len(); i++) tib_rom[base + i] = s[i];
    endtask

    task automatic issue(input dict_op o, input logic [16:0] a, input logic [7:0] l);
        @(posedge clk); #1;
        bus.op  = o;
        bus.ai  = a;
        bus.len = l;
        @(posedge clk); #1;
        bus.op  = NOP;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.bsy && cyc < 400) begin
            cyc++;
            @(posedge clk); #1;
        end
        if (bus.bsy) check("bsy_timeout", 32'(bus.bsy), 32'd0);
    endtask

    task automatic do_add(input string tag, input logic [16:0] a, input logic [7:0] l);
        logic [17:0] pfa;
        logic        pad;
        logic        ok;
        logic [16:0] wa;
        int          cyc;
        pfa = {1'b0, m_here} + 18'd3 + {10'd0, l};
        pad = 1'b0;
`ifdef DICT_ADD_ALIGN_EN
        pad = pfa[0];
`endif
        ok = (l != 8'd0) && (l <= 8'd31) && (m_here < 17'h10000) &&
             ((pfa + {17'd0, pad}) <= 18'h1ffff);
        if (ok) begin
            sb.push_back({m_here, m_ctx[7:0]});
            sb.push_back({17'(m_here + 17'd1), m_ctx[15:8]});
            sb.push_back({17'(m_here + 17'd2), l});
            for (int i = 0; i < int'(l); i++) begin
                wa = m_here + 17'(3 + i);
                sb.push_back({wa, tib_rom[int'(a) + i]});
            end
            if (pad) sb.push_back({pfa[16:0], 8'h00});
        end
        issue(ADD, a, l);
        wait_idle(cyc);
        check({tag, "_lat"}, 32'(cyc), ok ? 32'(4 + 2 * int'(l) + int'(pad)) : 32'd0);
        check({tag, "_err"}, 32'(bus.err), ok ? 32'd0 : 32'd1);
        if (ok) begin
            m_ctx  = m_here[15:0];
            m_here = pfa[16:0] + 17'(pad);
        end
        check({tag, "_here"}, 32'(bus.here), 32'(m_here));
        check({tag, "_ctx"}, 32'(bus.ctx), 32'(m_ctx));
        check({tag, "_sb"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        rst     = 1'b0;
        bus.op  = NOP;
        bus.ai  = '0;
        bus.len = '0;
        load_str('h40, "DUP");
        load_str('h50, "SWAP");
        load_str('h60, "WORDS");
        load_str('h70, "OR");
        m_here = 17'h100;
        m_ctx  = 16'hffff;

        repeat (3) @(posedge clk);
        #1;
        check("rst_bsy",    32'(bus.bsy),    32'd0);
        check("rst_err",    32'(bus.err),    32'd0);
        check("rst_we",     32'(bus.mem_we), 32'd0);
        check("rst_a",      32'(bus.mem_a),  32'd0);
        check("rst_vo",     32'(bus.mem_vo), 32'd0);
        check("rst_here",   32'(bus.here),   32'h100);
        check("rst_ctx",    32'(bus.ctx),    32'hffff);
        @(negedge clk) rst = 1'b1;

        // First word: link field carries the empty-chain terminator.
        do_add("dup", 17'h40, 8'd3);
        check("dup_here_abs", 32'(bus.here), 32'h106);
        check("dup_ctx_abs",  32'(bus.ctx),  32'h100);
        check("dup_m100", 32'(mem['h100]), 32'hff);
        check("dup_m101", 32'(mem['h101]), 32'hff);
        check("dup_m102", 32'(mem['h102]), 32'h03);
        check("dup_m103", 32'(mem['h103]), 32'h44);
        check("dup_m104", 32'(mem['h104]), 32'h55);
        check("dup_m105", 32'(mem['h105]), 32'h50);

        do_add("swap", 17'h50, 8'd4);
        check("swap_ctx_abs", 32'(bus.ctx), 32'h106);
`ifdef DICT_ADD_ALIGN_EN
        check("swap_here_abs", 32'(bus.here), 32'h10e);
`else
        check("swap_here_abs", 32'(bus.here), 32'h10d);
`endif
        // Walk from ctx the way FIND does: link, length, then the name.
        check("find_lfa", {16'd0, mem[bus.ctx + 16'd1], mem[bus.ctx]}, 32'h100);
        check("find_len", 32'(mem[bus.ctx + 16'd2]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            b = mem[bus.ctx + 16'(3 + i)];
            check("find_name", 32'(b), 32'(tib_rom['h50 + i]));
        end

        do_add("len0", 17'h40, 8'd0);
        do_add("len32", 17'h40, 8'd32);

        issue(LOAD, 17'h1fffe, 8'd0);
        check("load_err",  32'(bus.err),  32'd0);
        check("load_bsy",  32'(bus.bsy),  32'd0);
        check("load_here", 32'(bus.here), 32'h1fffe);
        m_here = 17'h1fffe;
        do_add("ovf", 17'h70, 8'd2);

        // Abort an ADD in its sixth busy cycle (the second RD).
        issue(LOAD, 17'h200, 8'd0);
        m_here = 17'h200;
        sb.push_back({17'h200, m_ctx[7:0]});
        sb.push_back({17'h201, m_ctx[15:8]});
        sb.push_back({17'h202, 8'd5});
        for (int i = 0; i < 5; i++) sb.push_back({17'(17'h203 + 17'(i)), tib_rom['h60 + i]});
        issue(ADD, 17'h60, 8'd5);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_written", 32'(sb.size()), 32'd4);
        sb.delete();
        #1;
        check("abort_bsy",  32'(bus.bsy),    32'd0);
        check("abort_we",   32'(bus.mem_we), 32'd0);
        check("abort_here", 32'(bus.here),   32'h100);
        check("abort_ctx",  32'(bus.ctx),    32'hffff);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        m_here = 17'h100;
        m_ctx  = 16'hffff;
        check("abort_err", 32'(bus.err), 32'd0);

        do_add("or", 17'h70, 8'd2);
`ifdef DICT_ADD_ALIGN_EN
        check("or_here_abs", 32'(bus.here), 32'h106);
        check("or_pad",      32'(mem['h105]), 32'h00);
`else
        check("or_here_abs", 32'(bus.here), 32'h105);
`endif

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dict_add.md
Name: dict_add

Overview:
- Dictionary writer that builds a new Forth word header at `here`; the counterpart of the pool FIND walker, which reads the same entry layout.
- Copies the name from TIB into the header, links the entry into the chain, then advances `ctx` and `here`.
- Owns the `here`/`ctx` registers and masters one synchronous single-port byte memory (spram8_128k, 1-cycle read latency).
- Entry layout: [lfa_lo][lfa_hi][len][name bytes...][pfa].

Parameters:
- DSZ, 8, memory data width (bytes).
- ASZ, 17, memory address width.
- NMAX, 31, maximum accepted name length.
- TOP, 'h1ffff, highest writable dictionary address.
- HERE0, 'h0100, reset value of here.
- CTX0, 'hffff, reset value of ctx; 'hffff is the empty-chain terminator.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- op  in  2  dict_op: NOP, ADD, LOAD; sampled only when bsy=0.
- ai  in  ASZ  TIB address of the name (ADD); new here value (LOAD).
- len  in  DSZ  name length (ADD).
- mem_we  out  1  memory write enable.
- mem_a  out  ASZ  memory address.
- mem_vo  out  DSZ  memory write data.
- mem_vi  in  DSZ  memory read data, valid 1 cycle after address.
- bsy  out  1  operation in progress.
- err  out  1  last ADD rejected; sticky until the next accepted op.
- here  out  ASZ  next free byte; equals the new pfa after ADD.
- ctx  out  16  address of the latest entry.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - bsy=0, err=0, mem_we=0, mem_a=0, mem_vo=0.
  - here=HERE0, ctx=CTX0.
  - Asserting reset mid-ADD aborts with no further writes; bytes already written stay in memory, here/ctx reload to their reset values.
- States: IDLE, LNK0, LNK1, HLEN, RD, WR, PAD (feature only), DONE.
- IDLE:
  - LOAD: here<=ai, err<=0, 1 cycle, bsy stays 0.
  - ADD checks: len==0, len>NMAX, or here+3+len(+pad) > TOP computed in ASZ+1 bits. Any failure sets err<=1, writes nothing, stays IDLE.
  - ADD accepted: err<=0, bsy<=1, latch tib<=ai, n<=len, base<=here, wp<=here; go to LNK0.
  - ADD/LOAD while bsy=1 are ignored.
- LNK0: write ctx[7:0] at wp; wp++; go to LNK1.
- LNK1: write ctx[15:8] at wp; wp++; go to HLEN.
- HLEN: write len at wp; wp++; go to RD.
- RD:
  - Drive mem_a=tib, mem_we=0; tib++; go to WR.
- WR:
  - Write mem_vi at wp; wp++; n--.
  - If n becomes 0: go to DONE (or PAD, see feature); otherwise go to RD.
  - The 2-cycle byte loop exists because read and write share one port.
- DONE:
  - here<=wp, ctx<=base[15:0], bsy<=0; go to IDLE.
  - Total ADD latency: 3 + 2*len + 1 cycles (bsy high count).
- Overlap: if the TIB and target ranges overlap, the copy is performed in ascending-address order; no other protection is provided.
- Link value: an old ctx of 'hffff is written verbatim, so the first word terminates the chain for FIND.
- Addressing: ctx is a 16-bit link, so entries must lie below 'h10000. base[16]=1 forces err at accept time.
- Address arithmetic is ASZ wide with no wrap; overflow is caught by the TOP check.

Optional Feature:
- Macro: DICT_ADD_ALIGN_EN.
- Defined:
  - After the last WR, if wp is odd, a PAD state writes 'h00 at wp and increments wp, so pfa (here) is always even.
  - Adds 1 cycle when padding occurs.
  - The TOP check includes the pad byte.
- Undefined: the PAD state does not exist; pfa = base+3+len, any parity.

Decomposition:
- Shared package pool_pkg:
  - dict_op enum {NOP, ADD, LOAD}.
  - dict_add state enum.
  - LFA_NIL='hffff.
  - HDR_SZ=3.
  - The existing pool_ops/pool_sts enums move into this package as well.
- No sub-module: the memory is instantiated externally and arbitrated at pool top.

Test Plan:
- Reset, then ADD ai='h40, len=3, TIB="DUP" at 'h40:
  - Memory 'h100..'h105 = ff,ff,03,'D','U','P'.
  - here='h106, ctx='h100, bsy high for 10 cycles.
- Second ADD len=4 "SWAP":
  - 'h106..'h108 = 00,01,04, name follows.
  - here='h10d, ctx='h106.
  - A pool FIND for "SWAP" hits with ao0='h10d.
- ADD len=0, then ADD len=32:
  - err=1 each time, mem_we never asserted, here/ctx unchanged.
- LOAD ai='h1fffe, then ADD len=2:
  - err=1 (overflow), no writes.
- ADD len=5, rst pulsed low at cycle 6:
  - Immediately bsy=0, here='h100, ctx='hffff.
  - No writes after reset is asserted.
- With DICT_ADD_ALIGN_EN, ADD len=2 at here='h100:
  - 'h105 = 00, here='h106.
  - Without the macro: here='h105.
